// File: rtl/picorv32_mem_arbiter2.sv
// Two-requester arbiter for the picorv32 native memory port.
// Registered downstream request, one transfer in flight, optional watchdog.
module picorv32_mem_arbiter2 #(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int          TIMEOUT_CYCLES = 0,
    parameter logic [31:0] ERR_RDATA      = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s0_valid,
    input  logic        s0_instr,
    input  logic [31:0] s0_addr,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_wstrb,
    output logic        s0_ready,
    output logic [31:0] s0_rdata,
    input  logic        s1_valid,
    input  logic        s1_instr,
    input  logic [31:0] s1_addr,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_wstrb,
    output logic        s1_ready,
    output logic [31:0] s1_rdata,
    output logic        m_valid,
    output logic        m_instr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t        state;
    state_t        state_d;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic          load;
    logic          done;
    logic          fire;
    logic          pick1;
    logic          busy;
    logic [31:0]   rdata;

    always_comb begin
        state_d = state;
        load    = 1'b0;
        done    = 1'b0;
        pick1   = 1'b0;
        busy    = (state != IDLE);
        fire    = WD_EN && busy && (cnt == CNT_LAST) && !m_ready;
        unique case (state)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    load = 1'b1;
                    // last_grant holds the index of the previous owner
                    if (s0_valid && s1_valid)
                        pick1 = FIXED_PRIORITY ? 1'b0 : !last_grant;
                    else
                        pick1 = s1_valid;
                    state_d = pick1 ? BUSY1 : BUSY0;
                end
            end
            BUSY0, BUSY1: begin
                if (m_ready || fire) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is masked during reset so an aborted transfer never handshakes
    assign s0_ready = resetn && (state == BUSY0) && ((m_valid && m_ready) || fire);
    assign s1_ready = resetn && (state == BUSY1) && ((m_valid && m_ready) || fire);
    assign rdata    = fire ? ERR_RDATA : m_rdata;
    assign s0_rdata = rdata;
    assign s1_rdata = rdata;

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_valid     <= 1'b0;
            m_instr     <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_instr <= pick1 ? s1_instr : s0_instr;
            m_addr  <= pick1 ? s1_addr  : s0_addr;
            m_wdata <= pick1 ? s1_wdata : s0_wdata;
            m_wstrb <= pick1 ? s1_wstrb : s0_wstrb;
            grant   <= pick1 ? 2'b10 : 2'b01;
            cnt     <= '0;
        end else if (done) begin
            m_valid    <= 1'b0;
            grant      <= 2'b00;
            last_grant <= (state == BUSY1);
            cnt        <= '0;
            if (fire)
                timeout_err <= 1'b1;
        end else if (WD_EN && busy) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter2.sv
// Directed bench for picorv32_mem_arbiter2: round-robin/watchdog instance
// plus a fixed-priority instance, handshakes checked through a scoreboard.
module tb_picorv32_mem_arbiter2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s0_valid, s0_instr, s1_valid, s1_instr;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic [3:0]  s0_wstrb, s1_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;

    logic        s0_ready, s1_ready, m_valid, m_instr, timeout_err;
    logic [31:0] s0_rdata, s1_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  grant;

    logic        fp_s0_valid, fp_s1_valid, fp_m_ready;
    logic        fp_s0_ready, fp_s1_ready, fp_m_valid, fp_m_instr, fp_timeout_err;
    logic [31:0] fp_s0_rdata, fp_s1_rdata, fp_m_addr, fp_m_wdata;
    logic [3:0]  fp_m_wstrb;
    logic [1:0]  fp_grant;

    typedef struct packed {
        logic        r1;
        logic        r0;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_obs;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    picorv32_mem_arbiter2 #(
        .FIXED_PRIORITY(1'b0),
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA(32'h0010_0073)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s0_valid(s0_valid), .s0_instr(s0_instr), .s0_addr(s0_addr),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_ready(s0_ready), .s0_rdata(s0_rdata),
        .s1_valid(s1_valid), .s1_instr(s1_instr), .s1_addr(s1_addr),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
        .s1_ready(s1_ready), .s1_rdata(s1_rdata),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    picorv32_mem_arbiter2 #(
        .FIXED_PRIORITY(1'b1),
        .TIMEOUT_CYCLES(0),
        .ERR_RDATA(32'h0010_0073)
    ) dut_fp (
        .clk(clk), .resetn(resetn),
        .s0_valid(fp_s0_valid), .s0_instr(s0_instr), .s0_addr(s0_addr),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_ready(fp_s0_ready), .s0_rdata(fp_s0_rdata),
        .s1_valid(fp_s1_valid), .s1_instr(s1_instr), .s1_addr(s1_addr),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
        .s1_ready(fp_s1_ready), .s1_rdata(fp_s1_rdata),
        .m_valid(fp_m_valid), .m_instr(fp_m_instr), .m_addr(fp_m_addr),
        .m_wdata(fp_m_wdata), .m_wstrb(fp_m_wstrb),
        .m_ready(fp_m_ready), .m_rdata(m_rdata),
        .grant(fp_grant), .timeout_err(fp_timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push(input logic r1, input logic r0, input logic [31:0] d);
        exp_t e;
        e.r1 = r1;
        e.r0 = r0;
        e.d  = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        s0_valid    = 1'b0;
        s1_valid    = 1'b0;
        fp_s0_valid = 1'b0;
        fp_s1_valid = 1'b0;
        m_ready     = 1'b0;
        nxt();
        nxt();
        resetn = 1'b1;
    endtask

    // Every ready pulse of the main instance must match the next queued entry
    always @(negedge clk) begin
        if (s0_ready || s1_ready) begin
            mon_obs.r1 = s1_ready;
            mon_obs.r0 = s0_ready;
            mon_obs.d  = s0_ready ? s0_rdata : s1_rdata;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL sb_unexpected: observed ready=%b%b rdata=%h, expected no handshake",
                       s1_ready, s0_ready, mon_obs.d);
            end else begin
                mon_e = sb.pop_front();
                assert (mon_obs === mon_e) else begin
                    errors++;
                    $error("FAIL sb_handshake: observed %h expected %h", mon_obs, mon_e);
                end
            end
        end
    end

    initial begin
        logic [1:0] eg;
        resetn      = 1'b0;
        s0_valid    = 1'b0;
        s0_instr    = 1'b0;
        s0_addr     = '0;
        s0_wdata    = '0;
        s0_wstrb    = '0;
        s1_valid    = 1'b0;
        s1_instr    = 1'b0;
        s1_addr     = '0;
        s1_wdata    = '0;
        s1_wstrb    = '0;
        m_ready     = 1'b0;
        m_rdata     = '0;
        fp_s0_valid = 1'b0;
        fp_s1_valid = 1'b0;
        fp_m_ready  = 1'b1;

        // Reset state
        nxt();
        nxt();
        smp();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_wstrb", m_wstrb, 0);
        chk("rst_m_instr", m_instr, 0);
        chk("rst_fp_grant", fp_grant, 0);

        // Single read from s0
        resetn   = 1'b1;
        s0_valid = 1'b1;
        s0_instr = 1'b1;
        s0_addr  = 32'h0000_0100;
        s0_wstrb = 4'b0000;
        nxt();
        smp();
        chk("rd_m_valid", m_valid, 1);
        chk("rd_m_addr", m_addr, 32'h100);
        chk("rd_m_instr", m_instr, 1);
        chk("rd_grant", grant, 2'b01);
        chk("rd_s0_ready_wait", s0_ready, 0);
        nxt();
        m_ready = 1'b1;
        m_rdata = 32'hDEAD_BEEF;
        push(1'b0, 1'b1, 32'hDEAD_BEEF);
        smp();
        chk("rd_s0_ready", s0_ready, 1);
        chk("rd_s0_rdata", s0_rdata, 32'hDEAD_BEEF);
        nxt();
        s0_valid = 1'b0;
        m_ready  = 1'b0;
        smp();
        chk("rd_done_m_valid", m_valid, 0);
        chk("rd_done_grant", grant, 0);
        chk("rd_done_s0_ready", s0_ready, 0);

        // Round-robin contest with m_ready tied high
        do_reset();
        s0_valid = 1'b1;
        s0_addr  = 32'h0000_1000;
        s0_instr = 1'b0;
        s1_valid = 1'b1;
        s1_addr  = 32'h0000_2000;
        m_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nxt();
            m_rdata = 32'hC000_0000 + i;
            if (i % 2 == 0)
                push(i % 4 == 2, i % 4 == 0, 32'hC000_0000 + i);
            eg = (i % 4 == 0) ? 2'b01 : (i % 4 == 2) ? 2'b10 : 2'b00;
            smp();
            chk($sformatf("rr_grant_%0d", i), grant, eg);
            chk($sformatf("rr_m_valid_%0d", i), m_valid, (i % 2 == 0));
            if (eg != 2'b00)
                chk($sformatf("rr_m_addr_%0d", i), m_addr,
                    (eg == 2'b01) ? 32'h1000 : 32'h2000);
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        m_ready  = 1'b0;

        // Write passthrough from s1
        do_reset();
        s1_valid = 1'b1;
        s1_addr  = 32'h0000_2004;
        s1_wdata = 32'h1234_5678;
        s1_wstrb = 4'b0011;
        nxt();
        smp();
        chk("wr_m_addr", m_addr, 32'h2004);
        chk("wr_m_wdata", m_wdata, 32'h1234_5678);
        chk("wr_m_wstrb", m_wstrb, 4'b0011);
        chk("wr_grant", grant, 2'b10);
        chk("wr_s0_ready_a", s0_ready, 0);
        nxt();
        m_ready = 1'b1;
        m_rdata = 32'h0000_0000;
        push(1'b1, 1'b0, 32'h0);
        smp();
        chk("wr_s1_ready", s1_ready, 1);
        chk("wr_s0_ready_b", s0_ready, 0);
        nxt();
        s1_valid = 1'b0;
        m_ready  = 1'b0;
        smp();
        chk("wr_s0_ready_c", s0_ready, 0);
        chk("wr_done_grant", grant, 0);

        // Watchdog fires in the 8th busy cycle
        do_reset();
        s0_valid = 1'b1;
        s0_addr  = 32'h0000_0300;
        m_rdata  = 32'h0BAD_0BAD;
        for (int k = 1; k <= 8; k++) begin
            nxt();
            if (k == 8)
                push(1'b0, 1'b1, 32'h0010_0073);
            smp();
            chk($sformatf("wd_s0_ready_%0d", k), s0_ready, (k == 8));
            chk($sformatf("wd_err_%0d", k), timeout_err, 0);
        end
        chk("wd_rdata", s0_rdata, 32'h0010_0073);
        nxt();
        s0_valid = 1'b0;
        smp();
        chk("wd_m_valid_low", m_valid, 0);
        chk("wd_grant_low", grant, 0);
        chk("wd_err_set", timeout_err, 1);
        repeat (3) nxt();
        smp();
        chk("wd_err_sticky", timeout_err, 1);
        do_reset();
        smp();
        chk("wd_err_cleared", timeout_err, 0);

        // Watchdog race: m_ready arrives in the 8th busy cycle
        s0_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            nxt();
            if (k == 8) begin
                m_ready = 1'b1;
                m_rdata = 32'h55AA_55AA;
                push(1'b0, 1'b1, 32'h55AA_55AA);
            end
            smp();
        end
        chk("wdr_rdata", s0_rdata, 32'h55AA_55AA);
        nxt();
        s0_valid = 1'b0;
        m_ready  = 1'b0;
        smp();
        chk("wdr_m_valid_low", m_valid, 0);
        chk("wdr_err_clear", timeout_err, 0);
        repeat (2) nxt();
        smp();
        chk("wdr_err_still_clear", timeout_err, 0);

        // Reset in the middle of a BUSY1 transfer
        s1_valid = 1'b1;
        s1_addr  = 32'h0000_4000;
        nxt();
        smp();
        chk("mr_grant_busy", grant, 2'b10);
        nxt();
        resetn  = 1'b0;
        m_ready = 1'b1;
        m_rdata = 32'h0000_0BAD;
        smp();
        chk("mr_s1_ready_in_reset", s1_ready, 0);
        nxt();
        smp();
        chk("mr_m_valid", m_valid, 0);
        chk("mr_grant", grant, 0);
        chk("mr_s1_ready", s1_ready, 0);
        resetn  = 1'b1;
        m_ready = 1'b0;
        nxt();
        smp();
        chk("mr_regrant", grant, 2'b10);
        chk("mr_m_addr", m_addr, 32'h4000);
        nxt();
        m_ready = 1'b1;
        m_rdata = 32'h0000_600D;
        push(1'b1, 1'b0, 32'h0000_600D);
        smp();
        chk("mr_s1_ready_done", s1_ready, 1);
        nxt();
        s1_valid = 1'b0;
        m_ready  = 1'b0;
        smp();
        chk("mr_grant_idle", grant, 0);

        // Fixed priority: s0 keeps winning while it stays valid
        do_reset();
        fp_s0_valid = 1'b1;
        fp_s1_valid = 1'b1;
        s0_addr     = 32'h0000_5000;
        s1_addr     = 32'h0000_6000;
        for (int i = 0; i < 6; i++) begin
            nxt();
            smp();
            chk($sformatf("fp_grant_%0d", i), fp_grant, (i % 2 == 0) ? 2'b01 : 2'b00);
            chk($sformatf("fp_s0_ready_%0d", i), fp_s0_ready, (i % 2 == 0));
            chk($sformatf("fp_s1_ready_%0d", i), fp_s1_ready, 0);
        end
        fp_s0_valid = 1'b0;
        nxt();
        smp();
        chk("fp_s1_grant", fp_grant, 2'b10);
        chk("fp_s1_addr", fp_m_addr, 32'h6000);
        chk("fp_s1_ready", fp_s1_ready, 1);
        fp_s1_valid = 1'b0;

        nxt();
        smp();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
